io_bus_arbiter: RTL

- Two-master arbiter for the internal 32-bit register bus to the slave subsystems.
- Master 0 is the uP interface bridge. Master 1 is a second on-chip bus master, e.g. a sequencer.
- Grants one master at a time, round-robin, using the 4-phase handshake (handshake_1 = request, handshake_2 = acknowledge).
- Latches the transaction, drives it to the slave side, returns read data, and times out slaves that never acknowledge.

---
 rtl/io_bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the 32-bit register bus. Each side uses a
// 4-phase handshake; slaves that never acknowledge are timed out.
module io_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_handshake_1,
  output logic        m0_handshake_2,
  input  logic        m0_RW,
  input  logic [7:0]  m0_reg_address,
  input  logic [31:0] m0_data_out,
  output logic [31:0] m0_data_in,
  input  logic        m1_handshake_1,
  output logic        m1_handshake_2,
  input  logic        m1_RW,
  input  logic [7:0]  m1_reg_address,
  input  logic [31:0] m1_data_out,
  output logic [31:0] m1_data_in,
  output logic        s_handshake_1,
  input  logic        s_handshake_2,
  output logic        s_RW,
  output logic [7:0]  s_reg_address,
  output logic [31:0] s_data_out,
  input  logic [31:0] s_data_in,
  output logic        grant,
  output logic        bus_timeout,
  output logic [7:0]  timeout_count,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a requester raises handshake_1 and holds it until handshake_2
  // rises; it then drops handshake_1, and handshake_2 falls one edge later.

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SLAVE_REQ  = 2'd1,
    S_MASTER_ACK = 2'd2
  } state_t;

  localparam logic [8:0] TO_LIM = TIMEOUT_CYCLES[8:0];

  state_t      r_state,   w_state_nx;
  logic        r_last,    w_last_nx;
  logic        r_grant,   w_grant_nx;
  logic        r_s_hs1,   w_s_hs1_nx;
  logic        r_m0_hs2,  w_m0_hs2_nx;
  logic        r_m1_hs2,  w_m1_hs2_nx;
  logic        r_s_rw,    w_s_rw_nx;
  logic [7:0]  r_s_addr,  w_s_addr_nx;
  logic [31:0] r_s_wdata, w_s_wdata_nx;
  logic [31:0] r_m0_din,  w_m0_din_nx;
  logic [31:0] r_m1_din,  w_m1_din_nx;
  logic [7:0]  r_cnt,     w_cnt_nx;
  logic        r_to_pulse, w_to_pulse_nx;
  logic [7:0]  r_to_count, w_to_count_nx;
  logic        w_sel;
  logic        w_gnt_hs1;
  logic [8:0]  w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_gnt_hs1 = r_grant ? m1_handshake_1 : m0_handshake_1;

  always_comb begin
    w_state_nx    = r_state;
    w_last_nx     = r_last;
    w_grant_nx    = r_grant;
    w_s_hs1_nx    = r_s_hs1;
    w_m0_hs2_nx   = r_m0_hs2;
    w_m1_hs2_nx   = r_m1_hs2;
    w_s_rw_nx     = r_s_rw;
    w_s_addr_nx   = r_s_addr;
    w_s_wdata_nx  = r_s_wdata;
    w_m0_din_nx   = r_m0_din;
    w_m1_din_nx   = r_m1_din;
    w_cnt_nx      = r_cnt;
    w_to_pulse_nx = 1'b0;
    w_to_count_nx = r_to_count;
    w_sel         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_handshake_1 || m1_handshake_1) begin
          // On a tie the master that was not served last wins.
          if (m0_handshake_1 && m1_handshake_1) w_sel = ~r_last;
          else                                  w_sel = m1_handshake_1;
          w_grant_nx   = w_sel;
          w_last_nx    = w_sel;
          w_s_rw_nx    = w_sel ? m1_RW          : m0_RW;
          w_s_addr_nx  = w_sel ? m1_reg_address : m0_reg_address;
          w_s_wdata_nx = w_sel ? m1_data_out    : m0_data_out;
          w_cnt_nx     = 8'd0;
          w_s_hs1_nx   = 1'b1;
          w_state_nx   = S_SLAVE_REQ;
        end
      end
      S_SLAVE_REQ: begin
        if (s_handshake_2) begin
          if (r_grant) begin w_m1_din_nx = s_data_in; w_m1_hs2_nx = 1'b1; end
          else         begin w_m0_din_nx = s_data_in; w_m0_hs2_nx = 1'b1; end
          w_s_hs1_nx = 1'b0;
          w_state_nx = S_MASTER_ACK;
        end else begin
          w_cnt_nx = w_cnt_inc[7:0];
          if (w_cnt_inc == TO_LIM) begin
            if (r_grant) begin w_m1_din_nx = TIMEOUT_DATA; w_m1_hs2_nx = 1'b1; end
            else         begin w_m0_din_nx = TIMEOUT_DATA; w_m0_hs2_nx = 1'b1; end
            w_to_pulse_nx = 1'b1;
            if (r_to_count != 8'hFF) w_to_count_nx = r_to_count + 8'd1;
            w_s_hs1_nx = 1'b0;
            w_state_nx = S_MASTER_ACK;
          end
        end
      end
      S_MASTER_ACK: begin
        if (!w_gnt_hs1 && !s_handshake_2) begin
          w_m0_hs2_nx = 1'b0;
          w_m1_hs2_nx = 1'b0;
          w_state_nx  = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_s_hs1    <= 1'b0;
      r_m0_hs2   <= 1'b0;
      r_m1_hs2   <= 1'b0;
      r_s_rw     <= 1'b0;
      r_s_addr   <= 8'd0;
      r_s_wdata  <= 32'd0;
      r_m0_din   <= 32'd0;
      r_m1_din   <= 32'd0;
      r_cnt      <= 8'd0;
      r_to_pulse <= 1'b0;
      r_to_count <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_last     <= w_last_nx;
      r_grant    <= w_grant_nx;
      r_s_hs1    <= w_s_hs1_nx;
      r_m0_hs2   <= w_m0_hs2_nx;
      r_m1_hs2   <= w_m1_hs2_nx;
      r_s_rw     <= w_s_rw_nx;
      r_s_addr   <= w_s_addr_nx;
      r_s_wdata  <= w_s_wdata_nx;
      r_m0_din   <= w_m0_din_nx;
      r_m1_din   <= w_m1_din_nx;
      r_cnt      <= w_cnt_nx;
      r_to_pulse <= w_to_pulse_nx;
      r_to_count <= w_to_count_nx;
    end
  end

  assign m0_handshake_2 = r_m0_hs2;
  assign m1_handshake_2 = r_m1_hs2;
  assign m0_data_in     = r_m0_din;
  assign m1_data_in     = r_m1_din;
  assign s_handshake_1  = r_s_hs1;
  assign s_RW           = r_s_rw;
  assign s_reg_address  = r_s_addr;
  assign s_data_out     = r_s_wdata;
  assign grant          = r_grant;
  assign bus_timeout    = r_to_pulse;
  assign timeout_count  = r_to_count;
  assign o_dbg_state    = r_state;

endmodule
